fp_unpack_seq: RTL and testbench

FP_UNPACK_SEQ -- requirements
Module: fp_unpack_seq

---
 rtl/fp_pkg.sv | 23 ++
 rtl/fp_classify.sv | 38 +++
 rtl/fp_unpack_seq.sv | 116 +++++++++++
 tb/tb_fp_unpack_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point format constants and unpacker state encodings.
package fp_pkg;

    localparam int FP16_EXP_W  = 5;
    localparam int FP16_FRAC_W = 10;
    localparam int FP32_EXP_W  = 8;
    localparam int FP32_FRAC_W = 23;
    localparam int BF16_EXP_W  = 8;
    localparam int BF16_FRAC_W = 7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_NORM = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef struct packed {
        logic subnorm;
        logic zero;
        logic inf;
        logic nan;
        logic snan;
    } fp_flags_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational field split and class decode of one packed IEEE-754 operand.
module fp_classify
    import fp_pkg::*;
#(
    parameter int EXP_W  = FP16_EXP_W,
    parameter int FRAC_W = FP16_FRAC_W
) (
    input  logic [EXP_W+FRAC_W:0] x_i,
    output logic                  sign_o,
    output logic [EXP_W+1:0]      exp_o,
    output logic [FRAC_W:0]       mant_o,
    output fp_flags_t             flags_o
);

    logic [EXP_W-1:0]  expField;
    logic [FRAC_W-1:0] fracField;
    logic              expMax;
    logic              expNonZero;
    logic              fracZero;

    assign expField   = x_i[EXP_W+FRAC_W-1:FRAC_W];
    assign fracField  = x_i[FRAC_W-1:0];
    assign expMax     = &expField;
    assign expNonZero = |expField;
    assign fracZero   = ~|fracField;

    // Subnormals and zero use the minimum exponent 1 with an implicit leading 0.
    assign sign_o = x_i[EXP_W+FRAC_W];
    assign exp_o  = {2'b00, expField} + {{(EXP_W+1){1'b0}}, ~expNonZero};
    assign mant_o = {expNonZero, fracField};

    assign flags_o.subnorm = ~expNonZero & ~fracZero;
    assign flags_o.zero    = ~expNonZero & fracZero;
    assign flags_o.inf     = expMax & fracZero;
    assign flags_o.nan     = expMax & ~fracZero;
    assign flags_o.snan    = expMax & ~fracZero & ~fracField[FRAC_W-1];

endmodule

// File: rtl/fp_unpack_seq.sv
// Handshaked operand unpacker; optionally normalises subnormals one bit per cycle.
module fp_unpack_seq
    import fp_pkg::*;
#(
    parameter int EXP_W        = FP16_EXP_W,
    parameter int FRAC_W       = FP16_FRAC_W,
    parameter int NORM_SUBNORM = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_W+FRAC_W:0] X,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  Xs,
    output logic [EXP_W+1:0]      Xe,
    output logic [FRAC_W:0]       Xm,
    output logic                  Xsubnorm,
    output logic                  Xzero,
    output logic                  Xinf,
    output logic                  XNaN,
    output logic                  XsNaN
);

    logic [1:0]         state_q, state_d;
    logic               xs_q, xs_d;
    logic [EXP_W+1:0]   xe_q, xe_d;
    logic [FRAC_W:0]    xm_q, xm_d;
    fp_flags_t          flags_q, flags_d;

    logic               clsSign;
    logic [EXP_W+1:0]   clsExp;
    logic [FRAC_W:0]    clsMant;
    fp_flags_t          clsFlags;
    logic               accept;
    logic [1:0]         loadState;

    fp_classify #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_classify (
        .x_i     (X),
        .sign_o  (clsSign),
        .exp_o   (clsExp),
        .mant_o  (clsMant),
        .flags_o (clsFlags)
    );

    assign in_ready  = ~reset & ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & out_ready));
    assign accept    = in_valid & in_ready;
    assign loadState = (clsFlags.subnorm && (NORM_SUBNORM != 0)) ? ST_NORM : ST_HOLD;

    // A new accept always wins: it can only happen in IDLE or while HOLD is draining.
    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        xe_d    = xe_q;
        xm_d    = xm_q;
        flags_d = flags_q;
        case (state_q)
            ST_NORM: begin
                xm_d = {xm_q[FRAC_W-1:0], 1'b0};
                xe_d = xe_q - {{(EXP_W+1){1'b0}}, 1'b1};
                if (xm_q[FRAC_W-1]) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (accept) begin
            state_d = loadState;
            xs_d    = clsSign;
            xe_d    = clsExp;
            xm_d    = clsMant;
            flags_d = clsFlags;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            xs_q    <= 1'b0;
            xe_q    <= '0;
            xm_q    <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            xe_q    <= xe_d;
            xm_q    <= xm_d;
            flags_q <= flags_d;
        end
    end

    assign out_valid = (state_q == ST_HOLD);
    assign Xs        = xs_q;
    assign Xe        = xe_q;
    assign Xm        = xm_q;
    assign Xsubnorm  = flags_q.subnorm;
    assign Xzero     = flags_q.zero;
    assign Xinf      = flags_q.inf;
    assign XNaN      = flags_q.nan;
    assign XsNaN     = flags_q.snan;

endmodule

// File: tb/tb_fp_unpack_seq.sv
// Bench for fp_unpack_seq: FP16 normalising, FP16 pass-through and FP32 instances.
module tb_fp_unpack_seq;

    typedef struct {
        logic [15:0] x;
        logic        s;
        logic [6:0]  e;
        logic [10:0] m;
        logic [4:0]  fl;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        inVal;
    logic        outRdy;
    logic [15:0] x16;
    logic [31:0] x32;

    logic        rdyA, vldA, sA, subA, zeroA, infA, nanA, snanA;
    logic [6:0]  eA;
    logic [10:0] mA;
    logic        rdyP, vldP, sP, subP, zeroP, infP, nanP, snanP;
    logic [6:0]  eP;
    logic [10:0] mP;
    logic        rdy32, vld32, s32, sub32, zero32, inf32, nan32, snan32;
    logic [9:0]  e32;
    logic [23:0] m32;
    logic [4:0]  flA, flP;

    int   nCompared = 0;
    int   nMismatched = 0;
    int   latA, latP, lat32;
    int   outCount;
    vec_t sbq[$];
    vec_t tbl[8];

    assign flA = {subA, zeroA, infA, nanA, snanA};
    assign flP = {subP, zeroP, infP, nanP, snanP};

    always #5 clk = ~clk;

    fp_unpack_seq dutA (
        .clk(clk), .reset(reset), .in_valid(inVal), .in_ready(rdyA), .X(x16),
        .out_valid(vldA), .out_ready(outRdy), .Xs(sA), .Xe(eA), .Xm(mA),
        .Xsubnorm(subA), .Xzero(zeroA), .Xinf(infA), .XNaN(nanA), .XsNaN(snanA)
    );

    fp_unpack_seq #(.EXP_W(5), .FRAC_W(10), .NORM_SUBNORM(0)) dutP (
        .clk(clk), .reset(reset), .in_valid(inVal), .in_ready(rdyP), .X(x16),
        .out_valid(vldP), .out_ready(outRdy), .Xs(sP), .Xe(eP), .Xm(mP),
        .Xsubnorm(subP), .Xzero(zeroP), .Xinf(infP), .XNaN(nanP), .XsNaN(snanP)
    );

    fp_unpack_seq #(.EXP_W(8), .FRAC_W(23), .NORM_SUBNORM(1)) dut32 (
        .clk(clk), .reset(reset), .in_valid(inVal), .in_ready(rdy32), .X(x32),
        .out_valid(vld32), .out_ready(outRdy), .Xs(s32), .Xe(e32), .Xm(m32),
        .Xsubnorm(sub32), .Xzero(zero32), .Xinf(inf32), .XNaN(nan32), .XsNaN(snan32)
    );

    // Reference: value-level view of the operand, normalised by doubling the significand.
    function automatic vec_t modelFp16(input logic [15:0] x, input bit norm);
        vec_t r;
        int ex, fr, e, m, n;
        ex = int'(x[14:10]);
        fr = int'(x[9:0]);
        r.x  = x;
        r.s  = x[15];
        r.fl = {ex == 0 && fr != 0, ex == 0 && fr == 0, ex == 31 && fr == 0,
                ex == 31 && fr != 0, ex == 31 && fr != 0 && fr < 512};
        e = (ex == 0) ? 1 : ex;
        m = ((ex == 0) ? 0 : 1024) + fr;
        n = 0;
        if (norm && ex == 0 && fr != 0) begin
            while (m < 1024) begin
                m = m * 2;
                e = e - 1;
                n++;
            end
        end
        r.e   = 7'(e);
        r.m   = 11'(m);
        r.lat = n + 1;
        return r;
    endfunction

    task automatic checkVal(input string nm, input int act, input int exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic checkOutput(input vec_t ex, input string tag);
        checkVal({tag, " Xs"}, int'(sA), int'(ex.s));
        checkVal({tag, " Xe"}, int'(eA), int'(ex.e));
        checkVal({tag, " Xm"}, int'(mA), int'(ex.m));
        checkVal({tag, " flags"}, int'(flA), int'(ex.fl));
    endtask

    // One streaming cycle on the FP16 normalising instance, scoreboarded.
    task automatic applyStimulus(input logic v, input logic [15:0] x, input logic rdy);
        logic inAcc, outAcc, stalled;
        vec_t snap;
        inVal  = v;
        x16    = x;
        outRdy = rdy;
        #1;
        inAcc   = v & rdyA;
        outAcc  = vldA & rdy;
        stalled = vldA & ~rdy;
        snap.s  = sA;
        snap.e  = eA;
        snap.m  = mA;
        snap.fl = flA;
        if (outAcc) begin
            outCount++;
            if (sbq.size() == 0) checkVal("unexpected output", 1, 0);
            else checkOutput(sbq.pop_front(), "stream");
        end
        @(posedge clk);
        #1;
        if (inAcc) sbq.push_back(modelFp16(x, 1'b1));
        if (stalled) begin
            checkVal("stall out_valid", int'(vldA), 1);
            checkOutput(snap, "stall");
        end
    endtask

    // Offer one operand to all instances while idle and measure each latency.
    task automatic runSingle(input logic [15:0] a, input logic [31:0] b);
        outRdy = 1'b0;
        inVal  = 1'b1;
        x16    = a;
        x32    = b;
        @(posedge clk);
        #1;
        inVal = 1'b0;
        latA = 0;
        latP = 0;
        lat32 = 0;
        for (int c = 1; c <= 40; c++) begin
            if (vldA && latA == 0) latA = c;
            if (vldP && latP == 0) latP = c;
            if (vld32 && lat32 == 0) lat32 = c;
            if (latA != 0 && latP != 0 && lat32 != 0) break;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drainAll();
        outRdy = 1'b1;
        @(posedge clk);
        #1;
        outRdy = 1'b0;
        checkVal("drained out_valid", int'(vldA), 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t pv;
        tbl[0] = '{16'h3C00, 1'b0, 7'd15,  11'h400, 5'b00000, 1};
        tbl[1] = '{16'h0001, 1'b0, 7'h77,  11'h400, 5'b10000, 11};
        tbl[2] = '{16'h7E00, 1'b0, 7'd31,  11'h600, 5'b00010, 1};
        tbl[3] = '{16'h7D00, 1'b0, 7'd31,  11'h500, 5'b00011, 1};
        tbl[4] = '{16'h8000, 1'b1, 7'd1,   11'h000, 5'b01000, 1};
        tbl[5] = '{16'h7C00, 1'b0, 7'd31,  11'h400, 5'b00100, 1};
        tbl[6] = '{16'h0200, 1'b0, 7'd0,   11'h400, 5'b10000, 2};
        tbl[7] = '{16'h83FF, 1'b1, 7'd0,   11'h7FE, 5'b10000, 2};

        reset  = 1'b1;
        inVal  = 1'b0;
        outRdy = 1'b0;
        x16    = '0;
        x32    = '0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset in_ready", int'(rdyA), 0);
        checkVal("reset out_valid", int'(vldA), 0);
        checkVal("reset Xe", int'(eA), 0);
        checkVal("reset Xm", int'(mA), 0);
        reset = 1'b0;
        #1;
        checkVal("in_ready after reset", int'(rdyA), 1);

        for (int i = 0; i < 8; i++) begin
            runSingle(tbl[i].x, 32'h0);
            checkVal($sformatf("vec%0d latency", i), latA, tbl[i].lat);
            checkOutput(tbl[i], $sformatf("vec%0d", i));
            pv = modelFp16(tbl[i].x, 1'b0);
            checkVal($sformatf("vec%0d pass latency", i), latP, 1);
            checkVal($sformatf("vec%0d pass Xe", i), int'(eP), int'(pv.e));
            checkVal($sformatf("vec%0d pass Xm", i), int'(mP), int'(pv.m));
            checkVal($sformatf("vec%0d pass flags", i), int'(flP), int'(pv.fl));
            drainAll();
        end

        runSingle(16'h3C00, 32'h0000_0001);
        checkVal("fp32 latency", lat32, 24);
        checkVal("fp32 Xe", int'(e32), 10'h3EA);
        checkVal("fp32 Xm", int'(m32), 24'h800000);
        checkVal("fp32 Xsubnorm", int'(sub32), 1);
        drainAll();

        inVal  = 1'b1;
        x16    = 16'h0001;
        outRdy = 1'b0;
        @(posedge clk);
        #1;
        inVal = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkVal("mid-norm reset in_ready", int'(rdyA), 0);
        @(posedge clk);
        #1;
        checkVal("mid-norm reset out_valid", int'(vldA), 0);
        checkVal("mid-norm reset Xs", int'(sA), 0);
        checkVal("mid-norm reset Xe", int'(eA), 0);
        checkVal("mid-norm reset Xm", int'(mA), 0);
        checkVal("mid-norm reset flags", int'(flA), 0);
        reset = 1'b0;
        #1;
        checkVal("post-reset in_ready", int'(rdyA), 1);
        runSingle(16'h3C00, 32'h0);
        checkVal("post-reset latency", latA, 1);
        checkOutput(tbl[0], "post-reset");
        drainAll();

        outCount = 0;
        applyStimulus(1'b1, 16'h3C00, 1'b0);
        repeat (3) applyStimulus(1'b1, 16'h4000, 1'b0);
        applyStimulus(1'b1, 16'h4000, 1'b1);
        applyStimulus(1'b1, 16'hC000, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkVal("b2b result count", outCount, 3);
        checkVal("b2b scoreboard empty", sbq.size(), 0);

        for (int i = 0; i < 400; i++) begin
            logic [15:0] rx;
            int cat;
            rx  = 16'($urandom);
            cat = int'($urandom_range(0, 3));
            if (cat == 0) rx[14:10] = 5'h00;
            if (cat == 1) rx[14:10] = 5'h1F;
            applyStimulus($urandom_range(0, 3) != 0, rx, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 200 && (sbq.size() != 0 || vldA); i++) begin
            applyStimulus(1'b0, 16'h0000, 1'b1);
        end
        checkVal("random scoreboard empty", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
